// File: rtl/id_stage_pipe.sv
// RV32I instruction-decode stage: field/immediate/control decode, register file and ID/EX register.
// Defining ID_WB_BYPASS_EN forwards a same-cycle write-back into the operand read.
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [4:0]      o_ex_rd,
    output logic [4:0]      o_ex_alu_ctrl,
    output logic [5:0]      o_ex_ctrl,
    output logic            o_ex_illegal
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b10111;
    localparam logic [4:0] ALU_SLTU = 5'b11000;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic idx_ok(input logic [4:0] idx);
        return ({27'd0, idx} < NREG);
    endfunction

    logic [6:0] opcode_s;
    logic [4:0] rd_s;
    logic [2:0] funct3_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [6:0] funct7_s;

    assign opcode_s = i_inst[6:0];
    assign rd_s     = i_inst[11:7];
    assign funct3_s = i_inst[14:12];
    assign rs1_s    = i_inst[19:15];
    assign rs2_s    = i_inst[24:20];
    assign funct7_s = i_inst[31:25];

    logic [XLEN-1:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s;

    assign imm_i_s  = {{(XLEN-11){i_inst[31]}}, i_inst[30:20]};
    assign imm_st_s = {{(XLEN-11){i_inst[31]}}, i_inst[30:25], i_inst[11:7]};
    assign imm_b_s  = {{(XLEN-12){i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u_s  = {{(XLEN-31){i_inst[31]}}, i_inst[30:12], 12'b0};
    assign imm_j_s  = {{(XLEN-20){i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    logic [XLEN-1:0] imm_s;
    logic [4:0]      alu_s;
    logic            regwrite_s, alu_src_s, memwrite_s, memtoreg_s, jal_s, beq_s;
    logic            rs1_used_s, rs2_used_s, bad_op_s;

    // Opcode/funct decode into immediate, ALU code, control bits and source usage.
    always_comb begin
        imm_s      = '0;
        alu_s      = ALU_ADD;
        regwrite_s = 1'b0;
        alu_src_s  = 1'b0;
        memwrite_s = 1'b0;
        memtoreg_s = 1'b0;
        jal_s      = 1'b0;
        beq_s      = 1'b0;
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        bad_op_s   = 1'b0;
        case (opcode_s)
            OP_LUI, OP_AUIPC: begin
                imm_s      = imm_u_s;
                regwrite_s = 1'b1;
                alu_src_s  = 1'b1;
            end
            OP_JAL: begin
                imm_s      = imm_j_s;
                regwrite_s = 1'b1;
                alu_src_s  = 1'b1;
                jal_s      = 1'b1;
            end
            OP_JALR: begin
                imm_s      = imm_i_s;
                regwrite_s = 1'b1;
                alu_src_s  = 1'b1;
                rs1_used_s = 1'b1;
                bad_op_s   = (funct3_s != 3'b000);
            end
            OP_BRANCH: begin
                imm_s      = imm_b_s;
                alu_s      = ALU_SUB;
                beq_s      = 1'b1;
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                bad_op_s   = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            end
            OP_LOAD: begin
                imm_s      = imm_i_s;
                regwrite_s = 1'b1;
                alu_src_s  = 1'b1;
                memtoreg_s = 1'b1;
                rs1_used_s = 1'b1;
                bad_op_s   = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
            end
            OP_STORE: begin
                imm_s      = imm_st_s;
                alu_src_s  = 1'b1;
                memwrite_s = 1'b1;
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                bad_op_s   = (funct3_s > 3'b010);
            end
            OP_IMM: begin
                imm_s      = imm_i_s;
                regwrite_s = 1'b1;
                alu_src_s  = 1'b1;
                rs1_used_s = 1'b1;
                case (funct3_s)
                    3'b000:  alu_s = ALU_ADD;
                    3'b010:  alu_s = ALU_SLT;
                    3'b011:  alu_s = ALU_SLTU;
                    3'b100:  alu_s = ALU_XOR;
                    3'b110:  alu_s = ALU_OR;
                    3'b111:  alu_s = ALU_AND;
                    3'b001: begin
                        alu_s    = ALU_SLL;
                        bad_op_s = (funct7_s != F7_ZERO);
                    end
                    3'b101: begin
                        if (funct7_s == F7_ALT) begin
                            alu_s = ALU_SRA;
                        end else begin
                            alu_s    = ALU_SRL;
                            bad_op_s = (funct7_s != F7_ZERO);
                        end
                    end
                    default: bad_op_s = 1'b1;
                endcase
            end
            OP_REG: begin
                regwrite_s = 1'b1;
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                case ({funct7_s, funct3_s})
                    {F7_ZERO, 3'b000}: alu_s = ALU_ADD;
                    {F7_ALT,  3'b000}: alu_s = ALU_SUB;
                    {F7_ZERO, 3'b001}: alu_s = ALU_SLL;
                    {F7_ZERO, 3'b010}: alu_s = ALU_SLT;
                    {F7_ZERO, 3'b011}: alu_s = ALU_SLTU;
                    {F7_ZERO, 3'b100}: alu_s = ALU_XOR;
                    {F7_ZERO, 3'b101}: alu_s = ALU_SRL;
                    {F7_ALT,  3'b101}: alu_s = ALU_SRA;
                    {F7_ZERO, 3'b110}: alu_s = ALU_OR;
                    {F7_ZERO, 3'b111}: alu_s = ALU_AND;
                    default:           bad_op_s = 1'b1;
                endcase
            end
            default: bad_op_s = 1'b1;
        endcase
    end

    // A register index outside the implemented file (RV32E) is only illegal where the field is used.
    logic reg_bad_s, illegal_s;
    logic [5:0] ctrl_s;
    logic [4:0] alu_f_s;

    assign reg_bad_s = (rs1_used_s && !idx_ok(rs1_s)) ||
                       (rs2_used_s && !idx_ok(rs2_s)) ||
                       (regwrite_s && !idx_ok(rd_s));
    assign illegal_s = bad_op_s || reg_bad_s;
    assign alu_f_s   = illegal_s ? ALU_ADD : alu_s;
    assign ctrl_s    = {regwrite_s && !illegal_s, alu_src_s, memwrite_s && !illegal_s,
                        memtoreg_s, jal_s, beq_s};

    logic [XLEN-1:0] rf_q [NREG];
    logic            wb_en_s;
    logic [XLEN-1:0] rs1_data_s, rs2_data_s;

    assign wb_en_s = i_wb_we && (i_wb_rd != 5'd0) && idx_ok(i_wb_rd);

    // Register file write port; reset clears every entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en_s) begin
            rf_q[i_wb_rd[RW-1:0]] <= i_wb_data;
        end
    end

    // Combinational operand read; x0 and unimplemented indices read as zero.
    always_comb begin
        if ((rs1_s != 5'd0) && idx_ok(rs1_s)) begin
            rs1_data_s = rf_q[rs1_s[RW-1:0]];
        end else begin
            rs1_data_s = '0;
        end
        if ((rs2_s != 5'd0) && idx_ok(rs2_s)) begin
            rs2_data_s = rf_q[rs2_s[RW-1:0]];
        end else begin
            rs2_data_s = '0;
        end
`ifdef ID_WB_BYPASS_EN
        if (wb_en_s && (i_wb_rd == rs1_s)) begin
            rs1_data_s = i_wb_data;
        end else begin
            rs1_data_s = rs1_data_s;
        end
        if (wb_en_s && (i_wb_rd == rs2_s)) begin
            rs2_data_s = i_wb_data;
        end else begin
            rs2_data_s = rs2_data_s;
        end
`endif
    end

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic [4:0]      ex_alu_q, ex_alu_d;
    logic [5:0]      ex_ctrl_q, ex_ctrl_d;
    logic            ex_ill_q, ex_ill_d;

    logic adv_s, hazard_s, accept_s;

    assign hazard_s = ex_valid_q && ex_ctrl_q[2] && (ex_rd_q != 5'd0) &&
                      ((rs1_used_s && (ex_rd_q == rs1_s)) || (rs2_used_s && (ex_rd_q == rs2_s)));
    assign adv_s      = !ex_valid_q || i_ex_ready;
    assign o_if_ready = i_flush || (adv_s && !hazard_s);
    assign accept_s   = adv_s && !hazard_s && !i_flush && i_if_valid;

    // ID/EX next state: flush kills, an open slot captures or bubbles, a stall holds.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_alu_d   = ex_alu_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_ill_d   = ex_ill_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (adv_s) begin
            if (accept_s) begin
                ex_valid_d = 1'b1;
                ex_pc_d    = i_pc;
                ex_rs1_d   = rs1_data_s;
                ex_rs2_d   = rs2_data_s;
                ex_imm_d   = imm_s;
                ex_rd_d    = rd_s;
                ex_alu_d   = alu_f_s;
                ex_ctrl_d  = ctrl_s;
                ex_ill_d   = illegal_s;
            end else begin
                ex_valid_d = 1'b0;
            end
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= 5'd0;
            ex_alu_q   <= 5'd0;
            ex_ctrl_q  <= 6'd0;
            ex_ill_q   <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_alu_q   <= ex_alu_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_ill_q   <= ex_ill_d;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_pc       = ex_pc_q;
    assign o_ex_rs1_data = ex_rs1_q;
    assign o_ex_rs2_data = ex_rs2_q;
    assign o_ex_imm      = ex_imm_q;
    assign o_ex_rd       = ex_rd_q;
    assign o_ex_alu_ctrl = ex_alu_q;
    assign o_ex_ctrl     = ex_ctrl_q;
    assign o_ex_illegal  = ex_ill_q;

endmodule
